// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports (s, t), one synchronous write port (d), r0 reads zero.
// Optional write-through forwarding on both read ports when REGFILE_WRITE_BYPASS_EN is defined.
`timescale 1ns/1ps

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] sAddr,
  input  logic [ADDR_WIDTH-1:0] tAddr,
  output logic [DATA_WIDTH-1:0] sData,
  output logic [DATA_WIDTH-1:0] tData
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // NOTE: the whole array sits on the async reset because every entry must read
  // a defined zero after reset; that rules out a RAM macro, which is fine at 32 entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write && (dAddr != '0)) begin
      regs[dAddr] <= data;
    end
  end

  // r0 is forced to zero on read as well, so it never depends on array contents.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    sData = (sAddr == '0) ? '0 : regs[sAddr];
    tData = (tAddr == '0) ? '0 : regs[tAddr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (reset && write && (dAddr != '0)) begin
      if (sAddr == dAddr) sData = data;
      if (tAddr == dAddr) tData = data;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expected values are hand-computed constants.
// Builds with or without REGFILE_WRITE_BYPASS_EN; only the read-during-write expectation differs.
`timescale 1ns/1ps

module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [4:0]  dAddr;
  logic [31:0] data;
  logic [4:0]  sAddr;
  logic [4:0]  tAddr;
  logic [31:0] sData;
  logic [31:0] tData;

  int passed = 0;
  int total  = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .write (write),
    .dAddr (dAddr),
    .data  (data),
    .sAddr (sAddr),
    .tAddr (tAddr),
    .sData (sData),
    .tData (tData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drive a write at a negedge so it is captured by the following posedge.
  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1;
    dAddr = a;
    data  = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  function automatic logic [31:0] sweepPattern(input logic [4:0] a);
    return {27'b0, a} ^ 32'hA5A5_A5A5;
  endfunction

  localparam logic [31:0] BYPASS_EXPECT =
`ifdef REGFILE_WRITE_BYPASS_EN
    32'h2;
`else
    32'h1;
`endif

  initial begin
    reset = 1'b0;
    write = 1'b0;
    dAddr = '0;
    data  = '0;
    sAddr = '0;
    tAddr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset clears storage asynchronously
    doWrite(5'd5, 32'h1234_5678);
    sAddr = 5'd5;
    #1 check("preload_r5", sData, 32'h1234_5678);
    #1 reset = 1'b0;
    #1 check("async_reset_r5", sData, 32'h0);
    write = 1'b1;
    dAddr = 5'd6;
    data  = 32'hCAFE_F00D;
    @(posedge clk);
    #1 write = 1'b0;
    sAddr = 5'd6;
    #1 check("write_during_reset_r6", sData, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tAddr = 5'(i);
      #1 check($sformatf("post_reset_t%0d", i), tData, 32'h0);
    end

    // Basic write/read
    doWrite(5'd1, 32'hFFFF_FFFF);
    sAddr = 5'd1;
    tAddr = 5'd1;
    #1 check("basic_s1", sData, 32'hFFFF_FFFF);
    check("basic_t1", tData, 32'hFFFF_FFFF);
    sAddr = 5'd2;
    #1 check("basic_s2", sData, 32'h0);

    // r0 hardwired
    doWrite(5'd0, 32'hDEAD_BEEF);
    sAddr = 5'd0;
    tAddr = 5'd0;
    #1 check("r0_s", sData, 32'h0);
    check("r0_t", tData, 32'h0);

    // Write-enable gating and unaligned control changes
    @(negedge clk);
    write = 1'b0;
    dAddr = 5'd7;
    data  = 32'h0000_00FF;
    repeat (3) @(posedge clk);
    #1 sAddr = 5'd7;
    #1 check("gated_r7", sData, 32'h0);
    @(negedge clk);
    write = 1'b1;
    dAddr = 5'd8;
    data  = 32'h0000_0011;
    #2 dAddr = 5'd10;
    data  = 32'h0000_0022;
    @(posedge clk);
    #1 write = 1'b0;
    dAddr = 5'd8;
    data  = 32'h0000_0033;
    #1 write = 1'b1;
    dAddr = 5'd12;
    data  = 32'h0000_0055;
    #2 write = 1'b0;
    @(posedge clk);
    #1 sAddr = 5'd10;
    tAddr = 5'd8;
    #1 check("edge_value_r10", sData, 32'h0000_0022);
    check("not_stored_r8", tData, 32'h0);
    sAddr = 5'd12;
    #1 check("short_pulse_r12", sData, 32'h0);

    // Read during write at the same address
    doWrite(5'd9, 32'h1);
    sAddr = 5'd9;
    tAddr = 5'd9;
    write = 1'b1;
    dAddr = 5'd9;
    data  = 32'h2;
    #1 check("rdw_before_s", sData, BYPASS_EXPECT);
    check("rdw_before_t", tData, BYPASS_EXPECT);
    @(posedge clk);
    #1 check("rdw_after_s", sData, 32'h2);
    check("rdw_after_t", tData, 32'h2);
    write = 1'b0;

    // Sweep: write 1..31, read s upward and t downward
    for (int a = 1; a < 32; a++) doWrite(5'(a), sweepPattern(5'(a)));
    for (int a = 1; a < 32; a++) begin
      sAddr = 5'(a);
      tAddr = 5'(32 - a);
      #1 check($sformatf("sweep_s%0d", a), sData, sweepPattern(5'(a)));
      check($sformatf("sweep_t%0d", 32 - a), tData, sweepPattern(5'(32 - a)));
    end
    sAddr = 5'd0;
    #1 check("sweep_r0", sData, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the CPU datapath: 32 registers × 32 bits.
- Two asynchronous (combinational) read ports, s and t, supply the ALU operands.
- One synchronous write port, d, takes writeback results.
- Register 0 is hardwired to zero, following MIPS convention.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of each address port; depth = 2**ADDR_WIDTH = 32 entries.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears every register to 0 while low.
- write  input  1  write enable for port d, sampled on the rising clk edge.
- dAddr  input  ADDR_WIDTH  destination register address for the write.
- data  input  DATA_WIDTH  write data.
- sAddr  input  ADDR_WIDTH  read address, port s.
- tAddr  input  ADDR_WIDTH  read address, port t.
- sData  output  DATA_WIDTH  contents of register sAddr.
- tData  output  DATA_WIDTH  contents of register tAddr.

Behaviour:
- Storage: 32 × 32-bit registers, indexed 0..31.
- Reset: reset low immediately (asynchronously) forces all registers to 0. sData and tData then read 0 for every address. Writes are ignored while reset is low.
- Reset release: the first write can take effect on the first rising clk edge with reset high.
- Write: on the rising clk edge with reset high and write=1, reg[dAddr] <= data. With write=0, no register changes.
- Register 0: a write with dAddr=0 is discarded. reg[0] always reads 0.
- Read: sData = reg[sAddr] and tData = reg[tAddr], combinational with zero-cycle latency. Outputs follow address changes within the same cycle with no clock involvement.
- Both read ports are fully independent. sAddr == tAddr is legal, and both outputs then show the same value.
- Read during write, same address, default build: reads return the old value until the rising edge. After the edge they return the new data, with no bypass.
- Glitch-free handling: write, dAddr and data may change at any time between edges (including mid-cycle). Only the values present at the rising edge matter.
- Reset asserted mid-cycle or coincident with a clk edge: reset wins and all registers become 0.
- No X propagation: every register has a defined value after reset.
- Unreset state: before the first reset, contents are unspecified. The bench shall assert reset first.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: internal write-through forwarding is enabled. When reset is high, write=1, dAddr != 0 and sAddr == dAddr, sData = data combinationally, before the clock edge. tData behaves the same way for tAddr. Storage update timing is unchanged.
- Undefined: no forwarding; reads reflect stored contents only, as in Behaviour.

Test Plan:
1. Reset clears storage: preload reg[5]=32'h1234_5678, then drive reset=0 with no clk edge → sData(sAddr=5)=0 immediately; after reset=1, tData for all 32 addresses = 0.
2. Basic write/read: write=1, dAddr=1, data=32'hFFFF_FFFF, one rising edge; then sAddr=1, tAddr=1 → sData=tData=32'hFFFF_FFFF. Also read sAddr=2 → 0.
3. R0 hardwired: write=1, dAddr=0, data=32'hDEAD_BEEF, edge → sData(sAddr=0)=0 and tData(tAddr=0)=0.
4. Sweep test:
   - sweep every address 1..31 writing data = {27'b0, addr} ^ 32'hA5A5_A5A5;
   - then sweep sAddr upward and tAddr downward simultaneously;
   - each output must equal its written pattern, with zero-cycle read latency after each address change.
5. Write-enable gating: write=0, dAddr=7, data=32'h0000_00FF, several edges → reg[7] unchanged at 0. Toggling write, dAddr and data between edges (write pulse not aligned to clk) → only the values at rising edges are stored.
6. Read-during-write, dAddr=sAddr=9, reg[9]=32'h1, data=32'h2, write=1:
   - before the edge: sData=32'h1 without the macro, 32'h2 with REGFILE_WRITE_BYPASS_EN;
   - after the edge: sData=32'h2 in both builds.
